load_store_unit: RTL and testbench

- Sits between the execute stage's ALU result and data_memory.
- Takes one load/store request from the core and converts RISC-V byte, half and word accesses into word-aligned memory accesses with byte enables.
- Splits word-crossing (misaligned) accesses into two memory accesses.
- Sign- or zero-extends load data and returns it with a one-cycle response strobe.

---
 rtl/lsu_pkg.sv | 38 +++
 rtl/lsu_load_align.sv | 26 ++
 rtl/load_store_unit.sv | 169 ++++++++++++++++
 tb/tb_load_store_unit.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 codes, FSM encoding and access-size helpers.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FIRST  = 2'd1,
    ST_SECOND = 2'd2,
    ST_DONE   = 2'd3
  } lsu_state_t;

  // Access size in bytes (1/2/4) from funct3[1:0]
  function automatic logic [2:0] size_bytes(input logic [1:0] f3_lo);
    case (f3_lo)
      2'b00:   return 3'd1;
      2'b01:   return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  // 8-lane byte mask spanning the addressed word and the one after it
  function automatic logic [7:0] lane_mask(input logic [1:0] f3_lo, input logic [1:0] off);
    logic [7:0] base;
    base = 8'((9'd1 << size_bytes(f3_lo)) - 9'd1);
    return base << off;
  endfunction

  function automatic logic f3_legal(input logic [2:0] f3, input logic store);
    if (store) return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) || (f3 == F3_BU) || (f3 == F3_HU);
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Extracts the addressed bytes from a two-word window and sign/zero-extends them.
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [63:0] data,
  input  logic [1:0]  off,
  input  logic [2:0]  funct3,
  output logic [31:0] result_c
);

  logic [31:0] word;

  always_comb begin
    word     = 32'(data >> {off, 3'b000});
    result_c = '0;
    case (funct3)
      F3_B:    result_c = {{24{word[7]}}, word[7:0]};
      F3_H:    result_c = {{16{word[15]}}, word[15:0]};
      F3_W:    result_c = word;
      F3_BU:   result_c = {24'h0, word[7:0]};
      F3_HU:   result_c = {16'h0, word[15:0]};
      default: result_c = '0;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Converts byte/half/word core accesses into word-aligned memory accesses with byte enables,
// splitting word-crossing accesses in two and returning extended load data.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_store,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_write_data,
  output logic [3:0]        mem_byte_en,
  output logic              MemRead,
  output logic              MemWrite,
  input  logic [DATA_W-1:0] mem_read_data
);

  lsu_state_t        state, state_nxt;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [2:0]        f3_q;
  logic              store_q;
  logic [DATA_W-1:0] lo_q, hi_q, lo_nxt, hi_nxt;
  logic [DATA_W-1:0] load_c;

  logic              accept;
  logic [ADDR_W-1:0] op_addr, aligned;
  logic [DATA_W-1:0] op_wdata;
  logic [1:0]        op_sz, off;
  logic [7:0]        mask;
  logic [63:0]       shifted;

  logic [ADDR_W-1:0] mem_addr_nxt;
  logic [DATA_W-1:0] mem_wd_nxt, resp_rdata_nxt;
  logic [3:0]        mem_be_nxt;
  logic              mem_rd_nxt, mem_wr_nxt, resp_valid_nxt, resp_err_nxt;

  // Ready is gated by reset so the core never sees a handshake during reset
  assign req_ready = (state == ST_IDLE) && reset;

  // Load words are captured as the memory returns them
  always_comb begin : capture
    lo_nxt = lo_q;
    hi_nxt = hi_q;
    if (!store_q) begin
      if (state == ST_FIRST)  lo_nxt = mem_read_data;
      if (state == ST_SECOND) hi_nxt = mem_read_data;
    end
  end

  lsu_load_align u_align (
    .data     ({hi_nxt, lo_nxt}),
    .off      (addr_q[1:0]),
    .funct3   (f3_q),
    .result_c (load_c)
  );

  always_comb begin : fsm_next
    state_nxt      = state;
    accept         = 1'b0;
    mem_addr_nxt   = '0;
    mem_be_nxt     = '0;
    mem_wd_nxt     = '0;
    mem_rd_nxt     = 1'b0;
    mem_wr_nxt     = 1'b0;
    resp_valid_nxt = 1'b0;
    resp_err_nxt   = 1'b0;
    resp_rdata_nxt = '0;

    // In IDLE the next access is built straight from the request being accepted
    op_addr  = (state == ST_IDLE) ? req_addr : addr_q;
    op_wdata = (state == ST_IDLE) ? req_wdata : wdata_q;
    op_sz    = (state == ST_IDLE) ? req_funct3[1:0] : f3_q[1:0];
    off      = op_addr[1:0];
    mask     = lane_mask(op_sz, off);
    shifted  = 64'(op_wdata) << {off, 3'b000};
    aligned  = {op_addr[ADDR_W-1:2], 2'b00};

    case (state)
      ST_IDLE: begin
        if (req_valid) begin
          accept = 1'b1;
          if (f3_legal(req_funct3, req_store)) begin
            state_nxt    = ST_FIRST;
            mem_addr_nxt = aligned;
            mem_be_nxt   = mask[3:0];
            mem_wd_nxt   = shifted[31:0];
            mem_wr_nxt   = req_store;
            mem_rd_nxt   = !req_store;
          end else begin
            state_nxt      = ST_DONE;
            resp_valid_nxt = 1'b1;
            resp_err_nxt   = 1'b1;
          end
        end
      end
      ST_FIRST: begin
        if (mask[7:4] != 4'h0) begin
          state_nxt    = ST_SECOND;
          mem_addr_nxt = aligned + ADDR_W'(4);
          mem_be_nxt   = mask[7:4];
          mem_wd_nxt   = shifted[63:32];
          mem_wr_nxt   = store_q;
          mem_rd_nxt   = !store_q;
        end else begin
          state_nxt      = ST_DONE;
          resp_valid_nxt = 1'b1;
          resp_rdata_nxt = store_q ? '0 : load_c;
        end
      end
      ST_SECOND: begin
        state_nxt      = ST_DONE;
        resp_valid_nxt = 1'b1;
        resp_rdata_nxt = store_q ? '0 : load_c;
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= ST_IDLE;
      addr_q         <= '0;
      wdata_q        <= '0;
      f3_q           <= '0;
      store_q        <= 1'b0;
      lo_q           <= '0;
      hi_q           <= '0;
      mem_addr       <= '0;
      mem_byte_en    <= '0;
      mem_write_data <= '0;
      MemRead        <= 1'b0;
      MemWrite       <= 1'b0;
      resp_valid     <= 1'b0;
      resp_err       <= 1'b0;
      resp_rdata     <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        f3_q    <= req_funct3;
        store_q <= req_store;
      end
      lo_q           <= lo_nxt;
      hi_q           <= hi_nxt;
      mem_addr       <= mem_addr_nxt;
      mem_byte_en    <= mem_be_nxt;
      mem_write_data <= mem_wd_nxt;
      MemRead        <= mem_rd_nxt;
      MemWrite       <= mem_wr_nxt;
      resp_valid     <= resp_valid_nxt;
      resp_err       <= resp_err_nxt;
      resp_rdata     <= resp_rdata_nxt;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: a byte-level reference memory predicts every memory access and response.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_store = 1'b0;
  logic [2:0]  req_funct3 = 3'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_addr;
  logic [31:0] mem_write_data;
  logic [3:0]  mem_byte_en;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] mem_read_data = '0;

  load_store_unit #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_addr(mem_addr), .mem_write_data(mem_write_data), .mem_byte_en(mem_byte_en),
    .MemRead(MemRead), .MemWrite(MemWrite), .mem_read_data(mem_read_data)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int unsigned lat;
    int unsigned acc;
  } resp_t;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  be;
    logic        wr;
    logic [31:0] wdata;
  } acc_t;

  resp_t resp_q[$];
  acc_t  acc_q[$];

  logic [7:0] dmem [int unsigned];
  logic [7:0] rmem [int unsigned];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_vec++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  function automatic logic [7:0] dmem_rd(input logic [31:0] a);
    return dmem.exists(a) ? dmem[a] : 8'h00;
  endfunction

  function automatic logic [7:0] rmem_rd(input logic [31:0] a);
    return rmem.exists(a) ? rmem[a] : 8'h00;
  endfunction

  function automatic logic [31:0] be_mask(input logic [3:0] be);
    return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  endfunction

  task automatic poke_word(input logic [31:0] a, input logic [31:0] d);
    for (int i = 0; i < 4; i++) begin
      dmem[a + 32'(i)] = d[8*i +: 8];
      rmem[a + 32'(i)] = d[8*i +: 8];
    end
  endtask

  // Memory behind the DUT: writes land mid-cycle, reads follow the registered address
  always @(negedge clk) begin
    if (reset && MemWrite)
      for (int l = 0; l < 4; l++)
        if (mem_byte_en[l]) dmem[mem_addr + 32'(l)] = mem_write_data[8*l +: 8];
  end

  always begin
    @(posedge clk);
    #1;
    mem_read_data = MemRead ? {dmem_rd(mem_addr + 32'd3), dmem_rd(mem_addr + 32'd2),
                               dmem_rd(mem_addr + 32'd1), dmem_rd(mem_addr)} : 32'h0;
  end

  // Monitor: compares every memory access and every response against the queues
  always @(negedge clk) begin
    acc_t  ea;
    resp_t er;
    if (reset) begin
      check("rw_exclusive", 32'(MemRead & MemWrite), 32'h0);
      if (!MemRead && !MemWrite) check("idle_byte_en", 32'(mem_byte_en), 32'h0);
      if (MemRead || MemWrite) begin
        if (acc_q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL unexpected_access: addr 0x%08h be %b (cycle %0d)", mem_addr, mem_byte_en, cyc);
        end else begin
          ea = acc_q.pop_front();
          check("acc_addr", mem_addr, ea.addr);
          check("acc_be", 32'(mem_byte_en), 32'(ea.be));
          check("acc_write", 32'(MemWrite), 32'(ea.wr));
          if (ea.wr) check("acc_wdata", mem_write_data & be_mask(ea.be), ea.wdata);
        end
      end
      if (resp_valid) begin
        if (resp_q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL unexpected_resp: rdata 0x%08h err %b (cycle %0d)", resp_rdata, resp_err, cyc);
        end else begin
          er = resp_q.pop_front();
          check("resp_rdata", resp_rdata, er.rdata);
          check("resp_err", 32'(resp_err), 32'(er.err));
          check("resp_latency", cyc - er.acc, er.lat);
        end
      end
    end
  end

  // Reference model: byte-by-byte view of the access; push_all=0 keeps only the first word
  task automatic predict(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, input logic push_all, output resp_t r);
    acc_t a0, a1;
    int unsigned sz;
    logic [31:0] v, b;
    logic legal;
    legal = st ? (f3 inside {3'd0, 3'd1, 3'd2}) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    r.acc = cyc; r.err = 1'b0; r.rdata = '0; r.lat = 1;
    if (!legal) begin
      r.err = 1'b1;
      return;
    end
    sz = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    a0.addr = addr & 32'hFFFF_FFFC; a0.be = '0; a0.wr = st; a0.wdata = '0;
    a1.addr = a0.addr + 32'd4;      a1.be = '0; a1.wr = st; a1.wdata = '0;
    v = '0;
    for (int i = 0; i < int'(sz); i++) begin
      b = addr + 32'(i);
      if ((b & 32'hFFFF_FFFC) == a0.addr) begin
        a0.be[b[1:0]] = 1'b1;
        a0.wdata[8*b[1:0] +: 8] = wd[8*i +: 8];
      end else begin
        a1.be[b[1:0]] = 1'b1;
        a1.wdata[8*b[1:0] +: 8] = wd[8*i +: 8];
      end
      if (st) begin
        if (push_all || (b & 32'hFFFF_FFFC) == a0.addr) rmem[b] = wd[8*i +: 8];
      end else v[8*i +: 8] = rmem_rd(b);
    end
    if (f3 == 3'b000) v = {{24{v[7]}}, v[7:0]};
    if (f3 == 3'b001) v = {{16{v[15]}}, v[15:0]};
    r.rdata = st ? 32'h0 : v;
    r.lat   = (a1.be != 4'h0) ? 3 : 2;
    acc_q.push_back(a0);
    if (a1.be != 4'h0 && push_all) acc_q.push_back(a1);
  endtask

  task automatic present(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, output logic ok);
    int k;
    @(negedge clk);
    req_valid = 1'b1; req_store = st; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    k = 0;
    while (!req_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    ok = req_ready;
    if (!ok) begin
      n_vec++; n_err++;
      $display("FAIL accept_timeout: req_ready 0 for %0d cycles, addr 0x%08h", k, addr);
      req_valid = 1'b0;
    end
  endtask

  task automatic scramble_req();
    req_valid = 1'b0;
    req_store = 1'($urandom); req_funct3 = 3'($urandom);
    req_addr = $urandom; req_wdata = $urandom;
  endtask

  task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, input logic has_exp, input logic [31:0] exp_rd);
    resp_t r;
    logic ok;
    present(st, f3, addr, wd, ok);
    if (!ok) return;
    predict(st, f3, addr, wd, 1'b1, r);
    if (has_exp) r.rdata = exp_rd;
    resp_q.push_back(r);
    @(posedge clk);
    #1 scramble_req();
  endtask

  task automatic drain(input string name);
    int k;
    k = 0;
    while ((resp_q.size() != 0 || acc_q.size() != 0) && k < 50) begin
      @(negedge clk);
      k++;
    end
    @(negedge clk);
    check({name, "_resp_q"}, 32'(resp_q.size()), 32'h0);
    check({name, "_acc_q"}, 32'(acc_q.size()), 32'h0);
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_ready"}, 32'(req_ready), 32'h0);
    check({name, "_resp"}, {29'h0, resp_valid, resp_err, MemRead | MemWrite}, 32'h0);
    check({name, "_rdata"}, resp_rdata, 32'h0);
    check({name, "_addr"}, mem_addr, 32'h0);
    check({name, "_wdata"}, mem_write_data, 32'h0);
    check({name, "_be"}, 32'(mem_byte_en), 32'h0);
  endtask

  initial begin
    resp_t r;
    logic  ok;
    reset = 1'b0;
    #12 check_reset_outputs("reset");
    @(negedge clk) reset = 1'b1;
    @(negedge clk) check("ready_after_reset", 32'(req_ready), 32'h1);

    // Directed cases from the access rules
    issue(1'b1, 3'b010, 32'h100, 32'hDEAD_BEEF, 1'b1, 32'h0);
    drain("sw");
    poke_word(32'h100, 32'h80FF_FFFF);
    issue(1'b0, 3'b000, 32'h103, 32'h0, 1'b1, 32'hFFFF_FF80);
    issue(1'b0, 3'b100, 32'h103, 32'h0, 1'b1, 32'h0000_0080);
    drain("lb");
    poke_word(32'h100, 32'h3344_AAAA);
    poke_word(32'h104, 32'hBBBB_1122);
    issue(1'b0, 3'b010, 32'h102, 32'h0, 1'b1, 32'h1122_3344);
    issue(1'b0, 3'b001, 32'h101, 32'h0, 1'b1, 32'h0000_44AA);
    issue(1'b1, 3'b001, 32'hFFFF_FFFF, 32'h0000_ABCD, 1'b1, 32'h0);
    issue(1'b0, 3'b101, 32'hFFFF_FFFF, 32'h0, 1'b1, 32'h0000_ABCD);
    issue(1'b0, 3'b001, 32'hFFFF_FFFF, 32'h0, 1'b1, 32'hFFFF_ABCD);
    issue(1'b0, 3'b011, 32'h100, 32'h0, 1'b1, 32'h0);
    issue(1'b1, 3'b100, 32'h100, 32'h1234_5678, 1'b1, 32'h0);
    issue(1'b0, 3'b010, 32'h100, 32'h0, 1'b1, 32'h3344_AAAA);
    drain("directed");

    // Randomized traffic in a small window plus the top-of-memory wrap region
    for (int i = 0; i < 300; i++) begin
      logic [31:0] a;
      a = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF8 + 32'($urandom_range(0, 7))
                                      : 32'h300 + 32'($urandom_range(0, 31));
      issue(1'($urandom), 3'($urandom), a, $urandom, 1'b0, 32'h0);
    end
    drain("random");

    // Reset during the second half of a word-crossing store
    poke_word(32'h200, 32'h0);
    poke_word(32'h204, 32'h0);
    present(1'b1, 3'b001, 32'h203, 32'h0000_5A5A, ok);
    if (ok) begin
      predict(1'b1, 3'b001, 32'h203, 32'h0000_5A5A, 1'b0, r);
      @(posedge clk);
      #1 scramble_req();
      @(posedge clk);
      #2 reset = 1'b0;
      #1 check_reset_outputs("abort");
      @(negedge clk);
      @(negedge clk) check("abort_ready_low", 32'(req_ready), 32'h0);
      reset = 1'b1;
      @(negedge clk);
      check("abort_ready_high", 32'(req_ready), 32'h1);
      check("abort_no_resp", 32'(resp_valid), 32'h0);
      issue(1'b0, 3'b101, 32'h203, 32'h0, 1'b1, 32'h0000_005A);
    end
    drain("final");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
